accfifo_drain_ctrl: RTL and testbench

- Read-side (drain) controller for a PE accumulator FIFO.
- On a start command it:
  - issues exactly drain_len single-cycle read strobes on the FIFO's out-read port;
  - captures the returned accumulator words after a fixed read latency;
  - arithmetic-shifts them, applies optional ReLU and saturates them to the output width;
  - streams the results on a valid/ready master interface toward the PE output bus.
- Credit-based issue plus a local skid buffer absorb downstream backpressure without losing data.

---
 rtl/accfifo_drain_ctrl.sv | 163 ++++++++++++++++
 tb/tb_accfifo_drain_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accfifo_drain_ctrl.sv
// Drain controller for the PE accumulator FIFO: credit-limited read issue, shift/ReLU/saturate
// at capture, and a small skid buffer feeding a valid/ready master port.
module accfifo_drain_ctrl #(
    parameter int DATA_W     = 24,
    parameter int OUT_W      = 16,
    parameter int CNT_W      = 6,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  drain_len,
    input  logic [4:0]        shamt,
    input  logic              relu_en,
    output logic              out_fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              busy,
    output logic              done
);
    // Handshake: a word moves when m_valid & m_ready are both high at a rising edge; while
    // m_valid is high and m_ready low, m_data is held and m_valid stays high.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);

    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              state;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        issued;
    logic [4:0]              shamt_q;
    logic                    relu_q;
    logic [RD_LATENCY-1:0]   tag_pipe;
    logic [INF_W-1:0]        inflight;
    logic [OUT_W-1:0]        skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        occ;
    logic                    push;
    logic                    pop;
    logic                    rd;
    logic                    drained;
    logic [31:0]             credit_sum;
    logic signed [DATA_W-1:0] shifted;
    logic signed [DATA_W-1:0] conv;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(tag_pipe[i]);
        end
    end

    assign pop  = (occ != '0) && m_ready;
    assign push = tag_pipe[RD_LATENCY-1];

    // A slot freed by this cycle's pop can already be promised to a new read.
    assign credit_sum = 32'(occ) + 32'(inflight) - 32'(pop);
    assign rd = (state == ST_DRAIN) && (issued < len_q) && (credit_sum < 32'(SKID_DEPTH));

    // Looking through the final pop lets done follow the last transfer by one cycle.
    assign drained = (issued == len_q) && (inflight == '0) &&
                     ((occ == '0) || ((occ == OCC_W'(1)) && pop));

    always_comb begin
        shifted = $signed(fifo_data) >>> shamt_q;
        conv    = shifted;
        if (relu_q && (shifted < 0)) begin
            conv = '0;
        end else if (shifted > SAT_MAX) begin
            conv = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            conv = SAT_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            issued  <= '0;
            shamt_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= drain_len;
                        shamt_q <= shamt;
                        relu_q  <= relu_en;
                        issued  <= '0;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd) begin
                        issued <= issued + CNT_W'(1);
                    end
                    if (drained) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                skid_mem[wr_ptr] <= OUT_W'(conv);
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    assign out_fifo_read = rd;
    assign m_valid       = (occ != '0);
    assign m_data        = skid_mem[rd_ptr];
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_accfifo_drain_ctrl.sv
// Bench for accfifo_drain_ctrl: FIFO read-port model, expected-word queue checked by a monitor.
module tb_accfifo_drain_ctrl;
    localparam int DATA_W = 24;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 6;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  drain_len;
    logic [4:0]        shamt;
    logic              relu_en;
    logic              out_fifo_read;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [OUT_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] fifo_q[$];

    int cyc = 0;
    int strobes = 0;
    int xfers = 0;
    int done_cnt = 0;
    int first_rd = -1;
    int last_rd = -1;
    int first_vld = -1;
    int last_xfer = -1;
    int done_cyc = -1;
    bit pend = 0;
    bit hold_v = 0;
    logic [OUT_W-1:0] hold_d = '0;
    bit bp_mode = 0;
    int bp_idx = 0;
    logic [3:0] bp_pat = 4'b1001;

    accfifo_drain_ctrl #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .RD_LATENCY(1), .SKID_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .drain_len(drain_len), .shamt(shamt),
        .relu_en(relu_en), .out_fifo_read(out_fifo_read), .fifo_data(fifo_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO read port: data for a strobe in cycle c is presented during cycle c+1.
    always @(posedge clk) begin
        #1;
        if (pend) begin
            pend = 0;
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            else fifo_data = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            if (bp_idx < 4) m_ready = bp_pat[bp_idx];
            else m_ready = 1'($urandom_range(0, 1));
            bp_idx++;
        end else begin
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(hold_d));
            end
            if (out_fifo_read) begin
                check("issue_credit",
                      32'((strobes - xfers - ((m_valid && m_ready) ? 1 : 0)) < 2), 32'd1);
                check("read_while_busy", 32'(busy), 32'd1);
                strobes++;
                pend = 1;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && m_ready) begin
                xfers++;
                last_xfer = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL m_data: got 0x%0h with no word expected (cycle %0d)", m_data, cyc);
                end else begin
                    logic [OUT_W-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL m_data: got 0x%0h expected 0x%0h (cycle %0d)", m_data, e, cyc);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
        end
    end

    task automatic clear_stats();
        strobes = 0; xfers = 0; done_cnt = 0;
        first_rd = -1; last_rd = -1; first_vld = -1; last_xfer = -1; done_cyc = -1;
    endtask

    task automatic load(input logic [DATA_W-1:0] w, input logic [OUT_W-1:0] e);
        fifo_q.push_back(w);
        exp_q.push_back(e);
    endtask

    task automatic start_drain(input int len, input int sh, input bit relu, output int sc);
        @(posedge clk);
        #1;
        drain_len = CNT_W'(len);
        shamt     = 5'(sh);
        relu_en   = relu;
        start     = 1'b1;
        sc        = cyc;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("done_count", 32'(done_cnt), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"},  32'(out_fifo_read), 32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_data"},  32'(m_data), 32'd0);
    endtask

    initial begin
        int sc;
        int n;
        rst_n = 1'b0; start = 1'b0; drain_len = '0; shamt = '0; relu_en = 1'b0;
        m_ready = 1'b1; fifo_data = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic drain with saturation at both ends.
        clear_stats();
        load(24'd100, 16'd100);
        load(-24'sd5, -16'sd5);
        load(24'd40000, 16'h7FFF);
        load(-24'sd40000, 16'h8000);
        start_drain(4, 0, 0, sc);
        wait_done(100);
        check("basic_strobes", 32'(strobes), 32'd4);
        check("basic_first_rd", 32'(first_rd), 32'(sc + 1));
        check("basic_last_rd", 32'(last_rd), 32'(sc + 4));
        check("basic_first_vld", 32'(first_vld), 32'(sc + 3));
        check("basic_last_xfer", 32'(last_xfer), 32'(sc + 6));
        check("basic_done_cyc", 32'(done_cyc), 32'(sc + 7));
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // Shift by 4 with ReLU.
        clear_stats();
        load(24'h000100, 16'd16);
        load(24'hFFFFD0, 16'd0);
        load(24'd15, 16'd0);
        start_drain(3, 4, 1, sc);
        wait_done(100);
        check("relu_strobes", 32'(strobes), 32'd3);
        check("relu_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure, shift by 2: floor rounding and saturation.
        clear_stats();
        bp_idx = 0;
        bp_mode = 1;
        load(24'd1000, 16'd250);
        load(-24'sd1000, -16'sd250);
        load(24'h7FFFFF, 16'h7FFF);
        load(24'h800000, 16'h8000);
        load(-24'sd1, -16'sd1);
        load(24'd7, 16'd1);
        load(-24'sd7, -16'sd2);
        load(24'd131072, 16'h7FFF);
        start_drain(8, 2, 0, sc);
        wait_done(400);
        bp_mode = 0;
        check("bp_strobes", 32'(strobes), 32'd8);
        check("bp_xfers", 32'(xfers), 32'd8);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Zero length.
        clear_stats();
        start_drain(0, 0, 0, sc);
        wait_done(50);
        check("zero_strobes", 32'(strobes), 32'd0);
        check("zero_no_valid", 32'(first_vld), 32'hFFFF_FFFF);
        check("zero_done_cyc", 32'(done_cyc), 32'(sc + 2));

        // Second start while busy is ignored.
        clear_stats();
        load(24'd1, 16'd1);
        load(-24'sd2, 16'd0);
        load(24'd3, 16'd3);
        load(-24'sd4, 16'd0);
        load(24'd32767, 16'd32767);
        start_drain(5, 0, 1, sc);
        repeat (2) @(posedge clk);
        #1;
        drain_len = CNT_W'(3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        check("busy_strobes", 32'(strobes), 32'd5);
        check("busy_xfers", 32'(xfers), 32'd5);
        check("busy_drained", 32'(exp_q.size()), 32'd0);

        // Reset after three of six reads.
        clear_stats();
        for (int i = 1; i <= 6; i++) load(DATA_W'(10 * i), OUT_W'(10 * i));
        start_drain(6, 0, 0, sc);
        n = 0;
        while (strobes < 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("rst_reads_before", 32'(strobes), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        repeat (10) @(posedge clk);
        check("post_rst_strobes", 32'(strobes), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(m_valid), 32'd0);
        check("post_rst_done", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
